// File: rtl/tdm_demux4_pkg.sv
// tdm_demux4_pkg: shared state/slot encodings for the four-channel TDM demultiplexer
package tdm_demux4_pkg;
   typedef enum logic {ST_HUNT = 1'b0, ST_LOCKED = 1'b1} state_t;
   typedef logic [1:0] slot_t;
   localparam slot_t SLOT_A = 2'd0;
   localparam slot_t SLOT_B = 2'd1;
   localparam slot_t SLOT_C = 2'd2;
   localparam slot_t SLOT_D = 2'd3;
   function automatic logic [3:0] onehot(slot_t s);
      return 4'b0001 << s;
   endfunction
endpackage

// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: serial receive side plus the four parallel channel outputs
interface tdm_demux4_if #(parameter int WIDTH = 8);
   logic din, din_valid, frame_sync;
   logic [WIDTH-1:0] a, b, c, d;
   logic [3:0] out_valid;
   logic [1:0] sel;
   logic locked, frame_err;
   modport master (output din, din_valid, frame_sync,
                   input a, b, c, d, out_valid, sel, locked, frame_err);
   modport slave (input din, din_valid, frame_sync,
                  output a, b, c, d, out_valid, sel, locked, frame_err);
endinterface

// File: rtl/tdm_deser.sv
// tdm_deser: slot shift register and bit counter; word_done flags the last bit of a slot
module tdm_deser #(parameter int WIDTH = 8) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   input  logic advance,
   input  logic restart,
   input  logic clear,
   output logic word_done,
   output logic first,
   output logic [WIDTH-1:0] word
);
   localparam int CW = $clog2(WIDTH);
   logic [WIDTH-2:0] shift_q;
   logic [CW-1:0] cnt_q;
   assign first = cnt_q == '0;
   assign word_done = advance && cnt_q == CW'(WIDTH - 1);
   assign word = {shift_q, din};
   always_ff @(posedge clk)
      if (rst || clear) begin
         shift_q <= '0;
         cnt_q <= '0;
      end else if (restart) begin
         shift_q <= (WIDTH-1)'(din);
         cnt_q <= CW'(1);
      end else if (advance) begin
         shift_q <= word[WIDTH-2:0];
         cnt_q <= word_done ? '0 : cnt_q + CW'(1);
      end
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: frame-synced 4-slot serial demultiplexer with HUNT/LOCKED alignment
module tdm_demux4 import tdm_demux4_pkg::*; #(parameter int WIDTH = 8) (
   input logic clk,
   input logic rst,
   tdm_demux4_if.slave bus
);
   state_t state_q, state_d;
   slot_t sel_q, sel_d;
   logic [WIDTH-1:0] chan_q [4];
   logic [WIDTH-1:0] word;
   logic [3:0] ov_q, ov_d;
   logic err_q, err_d;
   logic hunt, expect_sync, restart, advance, miss, word_done, first;
   assign hunt = state_q == ST_HUNT;
   assign expect_sync = sel_q == SLOT_A && first;
   // any qualified sync realigns to slot A, whether expected, unexpected or from HUNT
   assign restart = bus.din_valid && bus.frame_sync;
   assign advance = bus.din_valid && !bus.frame_sync && !hunt && !expect_sync;
   assign miss = bus.din_valid && !bus.frame_sync && !hunt && expect_sync;
   tdm_deser #(.WIDTH(WIDTH)) u_deser (
      .clk(clk), .rst(rst), .din(bus.din), .advance(advance), .restart(restart),
      .clear(miss), .word_done(word_done), .first(first), .word(word)
   );
   always_comb begin
      state_d = restart ? ST_LOCKED : miss ? ST_HUNT : state_q;
      sel_d = (restart || miss) ? SLOT_A : word_done ? slot_t'(sel_q + 2'd1) : sel_q;
      err_d = miss || (restart && !hunt && !expect_sync);
      ov_d = word_done ? onehot(sel_q) : 4'b0000;
   end
   always_ff @(posedge clk)
      if (rst) begin
         state_q <= ST_HUNT;
         sel_q <= SLOT_A;
         ov_q <= '0;
         err_q <= 1'b0;
         chan_q <= '{default: '0};
      end else begin
         state_q <= state_d;
         sel_q <= sel_d;
         ov_q <= ov_d;
         err_q <= err_d;
         if (word_done) chan_q[sel_q] <= word;
      end
   assign bus.a = chan_q[SLOT_A];
   assign bus.b = chan_q[SLOT_B];
   assign bus.c = chan_q[SLOT_C];
   assign bus.d = chan_q[SLOT_D];
   assign bus.out_valid = ov_q;
   assign bus.sel = sel_q;
   assign bus.locked = state_q == ST_LOCKED;
   assign bus.frame_err = err_q;
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: frame-position reference model compared every cycle, plus directed literal checks
module tb_tdm_demux4;
   localparam int W = 8;
   logic clk = 0, rst = 1;
   always #5 clk = ~clk;
   tdm_demux4_if #(.WIDTH(W)) bus ();
   tdm_demux4 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int vectors = 0, misc = 0, cyc = 0, scyc = 0, errs = 0;
   bit started = 0, stray = 0, lock_seen = 0;
   int pc[$];
   logic [3:0] pv[$];

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         misc++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
      end
   endtask

   // reference: position within the 4*W-bit frame and the bits collected for the current slot
   int pos = 0;
   bit aligned = 0;
   logic [31:0] acc;
   logic [W-1:0] mch [4];
   logic [3:0] mov;
   logic merr;
   logic [1:0] msel;
   always @(posedge clk) begin
      int p;
      bit al;
      logic [31:0] ac;
      logic [3:0] ov;
      logic er;
      cyc <= cyc + 1;
      p = pos; al = aligned; ac = acc; ov = 0; er = 0;
      if (rst) begin
         p = 0; al = 0; ac = 0;
         for (int i = 0; i < 4; i++) mch[i] <= '0;
      end else if (bus.din_valid) begin
         if (bus.frame_sync) begin
            er = al && p != 0;
            al = 1; p = 1; ac = {31'b0, bus.din};
         end else if (al) begin
            if (p == 0) begin
               er = 1; al = 0;
            end else begin
               ac = {ac[30:0], bus.din};
               p++;
               if (p % W == 0) begin
                  mch[p / W - 1] <= ac[W-1:0];
                  ov = 4'b0001 << (p / W - 1);
                  p = p % (4 * W);
               end
            end
         end
      end
      pos <= p; aligned <= al; acc <= ac; mov <= ov; merr <= er;
      msel <= al ? 2'((p / W) % 4) : 2'd0;
   end

   always @(negedge clk) if (started) begin
      chk("a", 32'(bus.a), 32'(mch[0]));
      chk("b", 32'(bus.b), 32'(mch[1]));
      chk("c", 32'(bus.c), 32'(mch[2]));
      chk("d", 32'(bus.d), 32'(mch[3]));
      chk("out_valid", 32'(bus.out_valid), 32'(mov));
      chk("sel", 32'(bus.sel), 32'(msel));
      chk("locked", 32'(bus.locked), 32'(aligned));
      chk("frame_err", 32'(bus.frame_err), 32'(merr));
      if (bus.out_valid != 0) begin
         pc.push_back(cyc);
         pv.push_back(bus.out_valid);
      end
      if (bus.frame_err === 1'b1) errs++;
      if (bus.locked === 1'b1) lock_seen = 1;
   end

   task automatic send_bit(input logic b, input logic fs, input int gap);
      bus.din = b;
      bus.din_valid = 1;
      bus.frame_sync = fs | (stray && $urandom_range(0, 199) == 0);
      @(negedge clk);
      if (fs) scyc = cyc;
      bus.din_valid = 0;
      bus.din = 1'($urandom_range(0, 1));
      bus.frame_sync = 1'($urandom_range(0, 1));
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_word(input logic [W-1:0] w, input logic sync, input int gap, input int nbits = W);
      for (int i = W - 1; i >= W - nbits; i--)
         send_bit(w[i], sync && i == W - 1,
                  gap >= 0 ? gap : ($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0));
   endtask

   task automatic send_frame(input logic [31:0] f, input logic sync, input int gap);
      send_word(f[31:24], sync, gap);
      send_word(f[23:16], 0, gap);
      send_word(f[15:8], 0, gap);
      send_word(f[7:0], 0, gap);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_log;
      pc.delete();
      pv.delete();
      errs = 0;
   endtask

   task automatic check_frame(input int lat, input int gap_sp);
      chk("pulse_count", pc.size(), 4);
      if (pc.size() == 4) begin
         chk("first_latency", pc[0] - scyc, lat);
         for (int k = 0; k < 4; k++) begin
            chk("pulse_onehot", 32'(pv[k]), 32'(4'b0001 << k));
            chk("pulse_spacing", pc[k] - pc[0], k * gap_sp);
         end
      end
      chk("lit_a", 32'(bus.a), 32'hA5);
      chk("lit_b", 32'(bus.b), 32'h3C);
      chk("lit_c", 32'(bus.c), 32'hF0);
      chk("lit_d", 32'(bus.d), 32'h0F);
      chk("lit_locked", 32'(bus.locked), 1);
   endtask

   initial begin
      bus.din = 0; bus.din_valid = 0; bus.frame_sync = 0;
      idle(2);
      started = 1;
      chk("rst_a", 32'(bus.a), 0);
      chk("rst_locked", 32'(bus.locked), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      rst = 0;
      // contiguous frame
      clear_log();
      send_frame(32'hA53CF00F, 1, 0);
      idle(2);
      check_frame(W - 1, W);
      // same frame with a gap after every bit
      clear_log();
      send_frame(32'hA53CF00F, 1, 1);
      idle(2);
      check_frame(2 * W - 2, 2 * W);
      // missing sync on the next frame
      clear_log();
      send_frame(32'h12345678, 0, 0);
      idle(2);
      chk("miss_errs", errs, 1);
      chk("miss_locked", 32'(bus.locked), 0);
      chk("miss_pulses", pc.size(), 0);
      chk("miss_a", 32'(bus.a), 32'hA5);
      chk("miss_d", 32'(bus.d), 32'h0F);
      // early sync three bits into slot B
      clear_log();
      send_word(8'h55, 1, 0);
      send_word(8'hC3, 0, 0, 3);
      send_frame(32'h11223344, 1, 0);
      idle(2);
      chk("early_errs", errs, 1);
      chk("early_pulses", pc.size(), 5);
      if (pc.size() == 5)
         for (int k = 0; k < 5; k++)
            chk("early_onehot", 32'(pv[k]), k == 0 ? 1 : 32'(4'b0001 << (k - 1)));
      chk("early_a", 32'(bus.a), 32'h11);
      chk("early_b", 32'(bus.b), 32'h22);
      chk("early_c", 32'(bus.c), 32'h33);
      chk("early_d", 32'(bus.d), 32'h44);
      // reset in the middle of slot C
      send_word(8'h66, 1, 0);
      send_word(8'h77, 0, 0);
      send_word(8'h99, 0, 0, 3);
      rst = 1;
      idle(1);
      chk("midrst_a", 32'(bus.a), 0);
      chk("midrst_b", 32'(bus.b), 0);
      chk("midrst_ov", 32'(bus.out_valid), 0);
      chk("midrst_locked", 32'(bus.locked), 0);
      chk("midrst_sel", 32'(bus.sel), 0);
      rst = 0;
      clear_log();
      send_frame($urandom, 0, 0);
      idle(2);
      chk("postrst_pulses", pc.size(), 0);
      chk("postrst_locked", 32'(bus.locked), 0);
      // 100 random bits, never a sync
      rst = 1;
      idle(1);
      rst = 0;
      clear_log();
      lock_seen = 0;
      repeat (100) send_bit(1'($urandom_range(0, 1)), 0, $urandom_range(0, 1));
      idle(1);
      chk("nosync_pulses", pc.size(), 0);
      chk("nosync_lock_seen", 32'(lock_seen), 0);
      // randomized frames with gaps, occasional missing and stray syncs
      stray = 1;
      repeat (80) send_frame($urandom, $urandom_range(0, 7) != 0, -1);
      stray = 0;
      idle(3);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
      $finish;
   end
endmodule
